// File: rtl/alvio_ram_init_ctrl.sv
// ---------------------------------------------------------------------------
// alvio_ram_init_ctrl
//
// Owns the single write port of the partitioned Active List violation RAM.
// After reset it writes zero to every entry. Afterwards it forwards client
// writes, except while it is re-zeroing partitions. A partition is re-zeroed
// when it powers up, and every active partition is re-zeroed when
// clearReq_i is pulsed.
//
// Ports
//   clk                clock
//   reset              synchronous, active-high reset
//   partitionActive_i  bit p set = partition p is powered
//   clearReq_i         one-cycle request to zero all active partitions
//   reqWe_i            client write enable
//   reqAddr_i          client write address
//   reqData_i          client write data
//   ramWe_o            RAM write enable
//   ramAddr_o          RAM write address
//   ramData_o          RAM write data (zero whenever the controller writes)
//   ramReady_o         high only while client writes are forwarded
//   reqDropped_o       client write was not performed this cycle
// ---------------------------------------------------------------------------
module alvio_ram_init_ctrl #(
  parameter int DEPTH         = 16,
  parameter int INDEX         = 4,
  parameter int WIDTH         = 8,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PARTS-1:0] partitionActive_i,
  input  logic                 clearReq_i,
  input  logic                 reqWe_i,
  input  logic [INDEX-1:0]     reqAddr_i,
  input  logic [WIDTH-1:0]     reqData_i,
  output logic                 ramWe_o,
  output logic [INDEX-1:0]     ramAddr_o,
  output logic [WIDTH-1:0]     ramData_o,
  output logic                 ramReady_o,
  output logic                 reqDropped_o
);

  localparam int OFF_W      = INDEX - NUM_PARTS_LOG;
  localparam int PART_DEPTH = DEPTH / NUM_PARTS;

  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(PART_DEPTH - 1);
  localparam logic [INDEX-1:0] CNT_LAST = INDEX'(DEPTH - 1);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    PCLEAR
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [INDEX-1:0]     cnt;
  logic [INDEX-1:0]     cnt_next;
  logic [NUM_PARTS-1:0] pend_mask;
  logic [NUM_PARTS-1:0] pend_next;
  logic [NUM_PARTS-1:0] prev_active;

  logic [NUM_PARTS-1:0]     rise;
  logic [NUM_PARTS-1:0]     clr_mask;
  logic [NUM_PARTS-1:0]     eff;
  logic [NUM_PARTS-1:0]     done_mask;
  logic [NUM_PARTS_LOG-1:0] cur;
  logic [NUM_PARTS_LOG-1:0] sweep_part;
  logic [OFF_W-1:0]         sweep_off;
  logic [NUM_PARTS_LOG-1:0] req_part;
  logic                     req_ok;
  logic                     stale;
  logic                     sweep_we;
  logic                     part_done;

  // Index of the lowest set bit; zero when the mask is empty.
  function automatic logic [NUM_PARTS_LOG-1:0] lowest_idx(
    input logic [NUM_PARTS-1:0] m
  );
    logic [NUM_PARTS_LOG-1:0] idx;
    idx = '0;
    for (int i = NUM_PARTS - 1; i >= 0; i--) begin
      if (m[i]) idx = NUM_PARTS_LOG'(i);
    end
    return idx;
  endfunction

  // During a partition clear, cnt holds {partition, offset} of the sweep in
  // progress. A zero offset means no partition has been started yet.
  assign sweep_part = cnt[INDEX-1:OFF_W];
  assign sweep_off  = cnt[OFF_W-1:0];

  assign rise     = partitionActive_i & ~prev_active;
  assign clr_mask = clearReq_i ? partitionActive_i : '0;
  assign eff      = pend_mask & partitionActive_i;
  assign cur      = lowest_idx(eff);

  assign req_part = reqAddr_i[INDEX-1:OFF_W];
  assign req_ok   = partitionActive_i[req_part];

  // A sweep in progress is abandoned when its partition is no longer the
  // one selected (it powered down, or a lower partition became pending).
  // That cycle performs no write; the partition restarts from offset 0
  // when it is selected again, so it never ends up half-zeroed.
  assign stale     = (sweep_off != '0) && ((eff == '0) || (cur != sweep_part));
  assign sweep_we  = (eff != '0) && !stale;
  assign part_done = sweep_we && (sweep_off == OFF_LAST);
  assign done_mask = part_done ? (NUM_PARTS'(1) << cur) : '0;

  // State register plus the sweep counter, pending mask and the previous
  // activity snapshot used to detect partitions that just powered up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      cnt         <= '0;
      pend_mask   <= '0;
      prev_active <= partitionActive_i;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pend_mask   <= pend_next;
      prev_active <= partitionActive_i;
    end
  end

  // Next-state logic. The full sweep after reset ignores activity changes
  // and clear requests. While re-zeroing, the pending mask drops bits of
  // partitions that powered down and merges newly requested ones; the
  // finished partition is cleared before the merge, so a clear request
  // arriving on its last write queues a fresh pass for it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pend_next  = pend_mask;
    case (state)
      INIT: begin
        cnt_next = cnt + INDEX'(1);
        if (cnt == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      IDLE: begin
        if ((rise != '0) || clearReq_i) begin
          pend_next  = rise | clr_mask;
          state_next = PCLEAR;
          cnt_next   = '0;
        end
      end
      PCLEAR: begin
        pend_next = ((pend_mask & ~done_mask) & partitionActive_i) | rise | clr_mask;
        if (sweep_we && !part_done) begin
          cnt_next = {cur, sweep_off + OFF_W'(1)};
        end else begin
          cnt_next = '0;
        end
        if (pend_next == '0) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = INIT;
        cnt_next   = '0;
        pend_next  = '0;
      end
    endcase
  end

  // Output decode. Client writes are forwarded only while idle, and only
  // to powered partitions; otherwise the port belongs to the sweeps and
  // always writes zero. Everything is quiet while reset is held.
  always_comb begin
    ramWe_o      = 1'b0;
    ramAddr_o    = '0;
    ramData_o    = '0;
    ramReady_o   = 1'b0;
    reqDropped_o = 1'b0;
    if (!reset) begin
      case (state)
        INIT: begin
          ramWe_o      = 1'b1;
          ramAddr_o    = cnt;
          reqDropped_o = reqWe_i;
        end
        IDLE: begin
          ramReady_o   = 1'b1;
          ramWe_o      = reqWe_i & req_ok;
          ramAddr_o    = reqAddr_i;
          ramData_o    = reqData_i;
          reqDropped_o = reqWe_i & ~req_ok;
        end
        PCLEAR: begin
          ramWe_o      = sweep_we;
          ramAddr_o    = {cur, sweep_off};
          reqDropped_o = reqWe_i;
        end
        default: begin
          ramWe_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alvio_ram_init_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alvio_ram_init_ctrl
//
// Bench for alvio_ram_init_ctrl. A behavioural model of the write-port owner
// (init sweep, pass-through, per-partition zeroing jobs) is compared with
// the DUT on every cycle, followed by literal expectations for the directed
// scenarios, then a long randomized run.
// ---------------------------------------------------------------------------
module tb_alvio_ram_init_ctrl;

  localparam int DEPTH         = 16;
  localparam int INDEX         = 4;
  localparam int WIDTH         = 8;
  localparam int NUM_PARTS     = 4;
  localparam int NUM_PARTS_LOG = 2;
  localparam int PART_DEPTH    = DEPTH / NUM_PARTS;

  localparam int M_INIT  = 0;
  localparam int M_IDLE  = 1;
  localparam int M_CLEAR = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_PARTS-1:0] partitionActive_i = 4'b0011;
  logic                 clearReq_i = 1'b0;
  logic                 reqWe_i = 1'b0;
  logic [INDEX-1:0]     reqAddr_i = '0;
  logic [WIDTH-1:0]     reqData_i = '0;
  logic                 ramWe_o;
  logic [INDEX-1:0]     ramAddr_o;
  logic [WIDTH-1:0]     ramData_o;
  logic                 ramReady_o;
  logic                 reqDropped_o;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: current mode, next init address, pending partitions and
  // the zeroing job in progress (partition and how many entries are done).
  int                   mMode = M_INIT;
  int                   mInitAddr = 0;
  logic [NUM_PARTS-1:0] mPend = '0;
  logic [NUM_PARTS-1:0] mPrev = 4'b0011;
  int                   mJobPart = 0;
  int                   mJobOff = 0;

  always #5 clk = ~clk;

  alvio_ram_init_ctrl #(
    .DEPTH(DEPTH),
    .INDEX(INDEX),
    .WIDTH(WIDTH),
    .NUM_PARTS(NUM_PARTS),
    .NUM_PARTS_LOG(NUM_PARTS_LOG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .partitionActive_i(partitionActive_i),
    .clearReq_i(clearReq_i),
    .reqWe_i(reqWe_i),
    .reqAddr_i(reqAddr_i),
    .reqData_i(reqData_i),
    .ramWe_o(ramWe_o),
    .ramAddr_o(ramAddr_o),
    .ramData_o(ramData_o),
    .ramReady_o(ramReady_o),
    .reqDropped_o(reqDropped_o)
  );

  // One comparison: counts it and reports a failure line on mismatch.
  task automatic checkField(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic rst, input logic [NUM_PARTS-1:0] act,
                               input logic clr, input logic we,
                               input logic [INDEX-1:0] addr,
                               input logic [WIDTH-1:0] data);
    @(posedge clk);
    #1;
    reset             = rst;
    partitionActive_i = act;
    clearReq_i        = clr;
    reqWe_i           = we;
    reqAddr_i         = addr;
    reqData_i         = data;
  endtask

  // Literal expectations for the current cycle, sampled mid-cycle.
  task automatic checkOutput(input string name, input logic we, input int addr,
                             input int data, input logic ready, input logic drop);
    @(negedge clk);
    checkField({name, ".we"}, 32'(ramWe_o), 32'(we));
    checkField({name, ".ready"}, 32'(ramReady_o), 32'(ready));
    checkField({name, ".dropped"}, 32'(reqDropped_o), 32'(drop));
    if (we) begin
      checkField({name, ".addr"}, 32'(ramAddr_o), addr);
      checkField({name, ".data"}, 32'(ramData_o), data);
    end
  endtask

  // Model-based compare on every cycle, then advance the model to the
  // state it will have after the coming rising edge.
  always @(negedge clk) begin : compare
    logic                 eWe;
    logic                 eReady;
    logic                 eDrop;
    int                   eAddr;
    int                   eData;
    int                   tgt;
    logic [NUM_PARTS-1:0] act;
    logic [NUM_PARTS-1:0] rise;
    act    = partitionActive_i;
    rise   = act & ~mPrev;
    eWe    = 1'b0;
    eReady = 1'b0;
    eDrop  = 1'b0;
    eAddr  = 0;
    eData  = 0;
    if (reset) begin
      mMode     = M_INIT;
      mInitAddr = 0;
      mPend     = '0;
      mJobOff   = 0;
      mJobPart  = 0;
    end else if (mMode == M_INIT) begin
      eWe   = 1'b1;
      eAddr = mInitAddr;
      eDrop = reqWe_i;
      mInitAddr++;
      if (mInitAddr == DEPTH) mMode = M_IDLE;
    end else if (mMode == M_IDLE) begin
      eReady = 1'b1;
      eAddr  = int'(reqAddr_i);
      eData  = int'(reqData_i);
      eWe    = reqWe_i && act[int'(reqAddr_i) / PART_DEPTH];
      eDrop  = reqWe_i && !eWe;
      if (rise != '0 || clearReq_i) begin
        mPend   = rise | (clearReq_i ? act : '0);
        mMode   = M_CLEAR;
        mJobOff = 0;
      end
    end else begin
      eDrop = reqWe_i;
      tgt   = -1;
      for (int p = NUM_PARTS - 1; p >= 0; p--) begin
        if (mPend[p] && act[p]) tgt = p;
      end
      if (mJobOff != 0 && tgt != mJobPart) begin
        mJobOff = 0;
      end else if (tgt >= 0) begin
        eWe      = 1'b1;
        eAddr    = tgt * PART_DEPTH + mJobOff;
        mJobPart = tgt;
        mJobOff++;
        if (mJobOff == PART_DEPTH) begin
          mPend[tgt] = 1'b0;
          mJobOff    = 0;
        end
      end
      mPend = (mPend & act) | rise | (clearReq_i ? act : '0);
      if (mPend == '0) mMode = M_IDLE;
    end
    mPrev = act;
    checkField("model.we", 32'(ramWe_o), 32'(eWe));
    checkField("model.ready", 32'(ramReady_o), 32'(eReady));
    checkField("model.dropped", 32'(reqDropped_o), 32'(eDrop));
    if (eWe) begin
      checkField("model.addr", 32'(ramAddr_o), eAddr);
      checkField("model.data", 32'(ramData_o), eData);
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [NUM_PARTS-1:0] curAct;

    // Reset for two cycles, then the full init sweep and ready.
    applyStimulus(1'b1, 4'b0011, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("reset", 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0011, 1'b0, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0, 4'd0, 8'h00);
      checkOutput("init_sweep", 1'b1, i, 0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("init_ready", 1'b0, 0, 0, 1'b1, 1'b0);

    // Pass-through to an active partition, drop to an inactive one.
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b1, 4'd5, 8'hA5);
    checkOutput("idle_write", 1'b1, 5, 8'hA5, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b1, 4'd9, 8'hA5);
    checkOutput("idle_drop", 1'b0, 9, 8'hA5, 1'b1, 1'b1);

    // Partition 2 powers up alongside a client write.
    applyStimulus(1'b0, 4'b0111, 1'b0, 1'b1, 4'd2, 8'h3C);
    checkOutput("rise_write", 1'b1, 2, 8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 4'd0, 8'h00);
      checkOutput("part2_clear", 1'b1, 8 + i, 0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("part2_ready", 1'b0, 0, 0, 1'b1, 1'b0);

    // Partition 3 powers up.
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("rise3", 1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 4'd0, 8'h00);
      checkOutput("part3_clear", 1'b1, 12 + i, 0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("part3_ready", 1'b0, 0, 0, 1'b1, 1'b0);

    // Clear request over all four partitions, with a client write mid-sweep.
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 4'd0, 8'h00);
    checkOutput("clear_req", 1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0, (i == 5), 4'd3, 8'hFF);
      checkOutput("clear_all", 1'b1, i, 0, 1'b0, (i == 5));
    end
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("clear_ready", 1'b0, 0, 0, 1'b1, 1'b0);

    // Partition 2 powers down mid-sweep while partition 3 powers up.
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("fall_only", 1'b0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("rise2_again", 1'b0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("p2_off0", 1'b1, 8, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("p2_off1", 1'b1, 9, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("p2_abandon", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0, 4'd0, 8'h00);
      checkOutput("p3_after_abandon", 1'b1, 12 + i, 0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("abandon_ready", 1'b0, 0, 0, 1'b1, 1'b0);

    // Reset in the middle of a partition sweep restarts the full sweep.
    applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("rise2_third", 1'b0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("p2b_off0", 1'b1, 8, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("p2b_off1", 1'b1, 9, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0111, 1'b0, 1'b1, 4'd1, 8'h11);
    checkOutput("mid_reset", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 4'd0, 8'h00);
      checkOutput("reinit_sweep", 1'b1, i, 0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 4'd0, 8'h00);
    checkOutput("reinit_ready", 1'b0, 0, 0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    curAct = 4'b0111;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) curAct = NUM_PARTS'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 299) == 0), curAct,
                    ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
                    INDEX'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 255)));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/alvio_ram_init_ctrl.md
Name: alvio_ram_init_ctrl

Overview:
- Sequencer and write-port owner for the partitioned Active List violation RAM, which has one write port, COMMIT_WIDTH read ports and NUM_PARTS power-gated partitions.
- After reset it sweeps every entry to zero through the single write port.
- It re-zeroes any partition that becomes active, and on request zeroes all active partitions.
- Outside these sweeps it passes the client write through and drives the RAM ready signal.

Parameters:
- DEPTH, 16, RAM entries; must be a power of 2 and equal 2^INDEX.
- INDEX, 4, address width.
- WIDTH, 8, data width.
- NUM_PARTS, 4, number of partitions; power of 2; PART_DEPTH = DEPTH/NUM_PARTS.
- NUM_PARTS_LOG, 2, log2(NUM_PARTS).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- partitionActive_i  in  NUM_PARTS  bit p=1 means partition p is powered/active.
- clearReq_i  in  1  one-cycle request to zero all active partitions.
- reqWe_i  in  1  client write enable.
- reqAddr_i  in  INDEX  client write address.
- reqData_i  in  WIDTH  client write data.
- ramWe_o  out  1  RAM write enable.
- ramAddr_o  out  INDEX  RAM write address.
- ramData_o  out  WIDTH  RAM write data.
- ramReady_o  out  1  high only in IDLE.
- reqDropped_o  out  1  client write not performed this cycle.

Behaviour:
- Partition of address a = a[INDEX-1:INDEX-NUM_PARTS_LOG]. Offset = low INDEX-NUM_PARTS_LOG bits.
- States: INIT, IDLE, PCLEAR. Registers: state, cnt (INDEX bits), pendMask (NUM_PARTS), prevActive (NUM_PARTS).
- Reset (any cycle, including mid-sweep): state=INIT, cnt=0, pendMask=0, prevActive=partitionActive_i.
  - Outputs while reset is high: ramWe_o=0, ramReady_o=0, reqDropped_o=0.
- INIT:
  - Each cycle: ramWe_o=1, ramAddr_o=cnt, ramData_o=0, cnt++.
  - Sweeps all DEPTH entries and ignores partitionActive_i.
  - At cnt==DEPTH-1: next state=IDLE, cnt=0.
  - First write occurs in the first cycle after reset deasserts; ramReady_o rises exactly DEPTH cycles later.
  - Activation edges and clearReq_i are ignored.
- Tracking: prevActive<=partitionActive_i every non-reset cycle. rise = partitionActive_i & ~prevActive.
- IDLE:
  - ramReady_o=1.
  - Combinational pass-through: ramWe_o = reqWe_i & partitionActive_i[part(reqAddr_i)]; ramAddr_o=reqAddr_i; ramData_o=reqData_i.
  - reqDropped_o = reqWe_i & ~ramWe_o, i.e. a write to an inactive partition is dropped.
  - If rise!=0 or clearReq_i: pendMask <= rise | (clearReq_i ? partitionActive_i : 0); next state=PCLEAR, cnt offset=0.
  - The client write in that same cycle is still performed.
- PCLEAR:
  - ramReady_o=0. All client writes are dropped: reqDropped_o=reqWe_i.
  - eff = pendMask & partitionActive_i; cur = lowest set bit of eff.
  - If eff!=0: ramWe_o=1, ramAddr_o={cur, offset}, ramData_o=0, offset++.
  - At offset==PART_DEPTH-1: clear pendMask[cur], offset=0.
  - Each cycle, pendMask <= (pendMask & partitionActive_i) | rise | (clearReq_i ? partitionActive_i : 0). Pending bits of deactivated partitions are discarded.
  - If the current partition deactivates mid-sweep: no write that cycle, offset resets to 0, and a later reactivation restarts that partition from offset 0.
  - If the next pendMask==0 (after the clear/merge): next state=IDLE.
  - If eff==0 this cycle: ramWe_o=0.
- Inactive partitions receive no writes except during INIT.
- ramReady_o is decoded from the state only.
- ramData_o=0 whenever the controller is writing.

Test Plan:
- DEPTH=16, NUM_PARTS=4, reset held 2 cycles then released, partitionActive_i=4'b0011 → writes addr 0..15 with data 0 on 16 consecutive cycles; ramReady_o=1 on cycle 17; reqDropped_o=0 throughout.
- In IDLE with active=0011, reqWe_i=1, addr 5, data 8'hA5 → same-cycle ramWe_o=1, addr 5, data A5. Same write to addr 9 → ramWe_o=0, reqDropped_o=1.
- In IDLE, active changes 0011→0111 with a concurrent client write to addr 2 → that write is performed. Next 4 cycles: addr 8,9,10,11, data 0, ramReady_o=0. Then ready=1.
- In IDLE with active=1111, clearReq_i pulse → 16 zero writes, addr 0..15 in order, ready=0 for 16 cycles. A client write during the sweep → reqDropped_o=1, ramWe_o reflects the sweep only.
- PCLEAR sweeping partition 2 at offset 1 (addr 9 written); partition 2 deactivates and partition 3 activates that cycle → no write that cycle. Next 4 cycles: addr 12..15. Ready after.
- Assert reset mid-PCLEAR (after addr 9) → after release a full INIT sweep addr 0..15, ready after 16 cycles.
